drr_class_demux: RTL

DRR_CLASS_DEMUX -- requirements
Module: drr_class_demux

---
 rtl/drr_class_demux.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/drr_class_demux.sv
// drr_class_demux: steers framed packets from one upstream stream to one of
// NUM_CLASSES class queues, chosen by data[2:0] of the 8'h55 start word.
// The datapath is shared: only the one-hot out_wr strobe selects the queue.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_data/in_ctrl/in_wr      upstream word, accepted when in_wr && in_rdy
//   in_rdy                     combinational accept (depends on state, out_rdy)
//   out_data/out_ctrl/out_wr   registered word and one-hot queue strobe
//   out_rdy                    per-queue space available
//   pkt_count                  forwarded packets per class (32 bits each)
//   drop_count                 packets dropped for an out-of-range class
//   frame_err_count            words discarded in IDLE that were not 8'h55
module drr_class_demux #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned NUM_CLASSES = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    input  logic                        in_wr,
    output logic                        in_rdy,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [CTRL_WIDTH-1:0]       out_ctrl,
    output logic [NUM_CLASSES-1:0]      out_wr,
    input  logic [NUM_CLASSES-1:0]      out_rdy,
    output logic [32*NUM_CLASSES-1:0]   pkt_count,
    output logic [31:0]                 drop_count,
    output logic [15:0]                 frame_err_count
);

    localparam int unsigned CLS_W      = 3;
    localparam int unsigned PKT_CNT_W  = 32;
    localparam int unsigned DROP_CNT_W = 32;
    localparam int unsigned FERR_CNT_W = 16;

    localparam logic [CTRL_WIDTH-1:0] CTRL_SOP  = CTRL_WIDTH'(8'h55);
    localparam logic [CTRL_WIDTH-1:0] CTRL_BODY = '0;

    typedef enum logic [1:0] {IDLE, HDR_WAIT, FORWARD, DROP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    run;
    logic [CLS_W-1:0]        cls_q, cls_d;
    logic [DATA_WIDTH-1:0]   hdr_data_q, hdr_data_d;
    logic                    seen_body_q, seen_body_d;
    logic [DATA_WIDTH-1:0]   out_data_d;
    logic [CTRL_WIDTH-1:0]   out_ctrl_d;
    logic [NUM_CLASSES-1:0]  out_wr_d;
    logic                    pkt_inc, drop_inc, ferr_inc;
    logic                    sel_rdy;
    logic [NUM_CLASSES-1:0]  cls_onehot;
    logic                    accept, sop, body, cls_valid;
    logic [PKT_CNT_W-1:0]    pkt_q [NUM_CLASSES];

    // Reset release synchroniser; accepting is held off until it settles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], 1'b1};
    end
    assign run = sync_q[1];

    // Decode the latched class into a ready select and a one-hot strobe.
    always_comb begin
        sel_rdy    = 1'b0;
        cls_onehot = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (cls_q == CLS_W'(k)) begin
                sel_rdy       = out_rdy[k];
                cls_onehot[k] = 1'b1;
            end
        end
    end

    // Upstream ready: only the selected queue's out_rdy matters.
    always_comb begin
        in_rdy = 1'b0;
        if (run) begin
            case (state_q)
                IDLE, DROP: in_rdy = 1'b1;
                FORWARD:    in_rdy = sel_rdy;
                default:    in_rdy = 1'b0;
            endcase
        end
    end

    assign accept    = in_wr && in_rdy;
    assign sop       = (in_ctrl == CTRL_SOP);
    assign body      = (in_ctrl == CTRL_BODY);
    assign cls_valid = (32'(in_data[CLS_W-1:0]) < NUM_CLASSES);

    // Next state, next registered outputs and counter increments.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        hdr_data_d  = hdr_data_q;
        seen_body_d = seen_body_q;
        out_data_d  = out_data;
        out_ctrl_d  = out_ctrl;
        out_wr_d    = '0;
        pkt_inc     = 1'b0;
        drop_inc    = 1'b0;
        ferr_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sop) begin
                        seen_body_d = 1'b0;
                        if (cls_valid) begin
                            cls_d      = in_data[CLS_W-1:0];
                            hdr_data_d = in_data;
                            state_d    = HDR_WAIT;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = DROP;
                        end
                    end else begin
                        ferr_inc = 1'b1;
                    end
                end
            end
            HDR_WAIT: begin
                if (sel_rdy) begin
                    out_data_d = hdr_data_q;
                    out_ctrl_d = CTRL_SOP;
                    out_wr_d   = cls_onehot;
                    state_d    = FORWARD;
                end
            end
            FORWARD: begin
                if (accept) begin
                    out_data_d = in_data;
                    out_ctrl_d = in_ctrl;
                    out_wr_d   = cls_onehot;
                    if (body) begin
                        seen_body_d = 1'b1;
                    end else if (seen_body_q) begin
                        seen_body_d = 1'b0;
                        pkt_inc     = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (body) begin
                        seen_body_d = 1'b1;
                    end else if (seen_body_q) begin
                        seen_body_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched header and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cls_q           <= '0;
            hdr_data_q      <= '0;
            seen_body_q     <= 1'b0;
            out_data        <= '0;
            out_ctrl        <= '0;
            out_wr          <= '0;
            drop_count      <= '0;
            frame_err_count <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            hdr_data_q  <= hdr_data_d;
            seen_body_q <= seen_body_d;
            out_data    <= out_data_d;
            out_ctrl    <= out_ctrl_d;
            out_wr      <= out_wr_d;
            if (drop_inc) drop_count      <= drop_count + DROP_CNT_W'(1);
            if (ferr_inc) frame_err_count <= frame_err_count + FERR_CNT_W'(1);
        end
    end

    // Per-class packet counters; bumped on the EOP accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) pkt_q[k] <= '0;
        end else if (pkt_inc) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                if (cls_q == CLS_W'(k)) pkt_q[k] <= pkt_q[k] + PKT_CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pkt
        assign pkt_count[PKT_CNT_W*g +: PKT_CNT_W] = pkt_q[g];
    end

endmodule
